// File: rtl/conv_loop_seq_l1.sv
// Layer-1 convolution loop-nest sequencer: walks x, y, k, j and issues one MAC tap per unstalled RUN cycle.
// Taps start the cycle after start; out_wr lags its last tap by MAC_LAT; stall freezes issue but not the write delay line.
module conv_loop_seq_l1 #(
    parameter int OUT_W   = 30,
    parameter int OUT_H   = 30,
    parameter int K_H     = 3,
    parameter int K_W     = 3,
    parameter int STRIDE  = 1,
    parameter int IN_W    = (OUT_W - 1) * STRIDE + K_W,
    parameter int AW      = 12,
    parameter int MAC_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stall,
    output logic          busy,
    output logic          done,
    output logic          mac_valid,
    output logic          acc_clr,
    output logic          acc_last,
    output logic [4:0]    x_idx,
    output logic [4:0]    y_idx,
    output logic [1:0]    k_idx,
    output logic [1:0]    j_idx,
    output logic [AW-1:0] in_addr,
    output logic          out_wr,
    output logic [AW-1:0] out_addr
);

    localparam int IN_H = (OUT_H - 1) * STRIDE + K_H;

    // Reject geometries the fixed-width index ports or the address width cannot represent.
    generate
        if (OUT_W < 1 || OUT_W > 32 || OUT_H < 1 || OUT_H > 32) begin : g_bad_out
            $error("conv_loop_seq_l1: OUT_W/OUT_H must be in 1..32");
        end
        if (K_H < 1 || K_H > 4 || K_W < 1 || K_W > 4) begin : g_bad_kernel
            $error("conv_loop_seq_l1: K_H/K_W must be in 1..4");
        end
        if (STRIDE < 1 || MAC_LAT < 1 || AW < 1 || AW > 31) begin : g_bad_misc
            $error("conv_loop_seq_l1: STRIDE, MAC_LAT and AW must be positive, AW <= 31");
        end
        if (longint'(IN_W) * longint'(IN_H) > (longint'(1) << AW)) begin : g_bad_in_aw
            $error("conv_loop_seq_l1: input feature map does not fit in AW");
        end
        if (longint'(OUT_W) * longint'(OUT_H) > (longint'(1) << AW)) begin : g_bad_out_aw
            $error("conv_loop_seq_l1: output feature map does not fit in AW");
        end
    endgenerate

    localparam logic [4:0] X_MAX = 5'(OUT_W - 1);
    localparam logic [4:0] Y_MAX = 5'(OUT_H - 1);
    localparam logic [1:0] K_MAX = 2'(K_H - 1);
    localparam logic [1:0] J_MAX = 2'(K_W - 1);
    localparam int         DCW   = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [DCW-1:0] D_MAX = DCW'(MAC_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [4:0]     r_x;
    logic [4:0]     r_y;
    logic [1:0]     r_k;
    logic [1:0]     r_j;
    logic [DCW-1:0] r_drain;
    logic [MAC_LAT-1:0] r_wr_pipe;
    logic [AW-1:0]  r_oaddr_pipe [MAC_LAT];

    logic           w_issue;
    logic           w_j_wrap;
    logic           w_k_wrap;
    logic           w_x_wrap;
    logic           w_y_wrap;
    logic           w_last_tap;
    logic           w_acc_last;
    logic [AW-1:0]  w_in_addr;
    logic [AW-1:0]  w_out_addr;

    assign w_issue    = (r_state == S_RUN) && !stall;
    assign w_j_wrap   = (r_j == J_MAX);
    assign w_k_wrap   = (r_k == K_MAX);
    assign w_x_wrap   = (r_x == X_MAX);
    assign w_y_wrap   = (r_y == Y_MAX);
    assign w_acc_last = w_issue && w_k_wrap && w_j_wrap;
    assign w_last_tap = w_acc_last && w_x_wrap && w_y_wrap;

    // All address math is done at AW bits so overflow wraps exactly as the memories see it.
    assign w_in_addr  = ((AW'(r_y) * AW'(STRIDE) + AW'(r_k)) * AW'(IN_W))
                      + AW'(r_x) * AW'(STRIDE) + AW'(r_j);
    assign w_out_addr = AW'(r_y) * AW'(OUT_W) + AW'(r_x);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last_tap) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_drain == D_MAX) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Innermost first: j, then k, then x, then y; the final tap wraps everything back to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x <= '0;
            r_y <= '0;
            r_k <= '0;
            r_j <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_x <= '0;
            r_y <= '0;
            r_k <= '0;
            r_j <= '0;
        end else if (w_issue) begin
            if (w_j_wrap) begin
                r_j <= '0;
                if (w_k_wrap) begin
                    r_k <= '0;
                    if (w_x_wrap) begin
                        r_x <= '0;
                        r_y <= w_y_wrap ? '0 : r_y + 5'd1;
                    end else begin
                        r_x <= r_x + 5'd1;
                    end
                end else begin
                    r_k <= r_k + 2'd1;
                end
            end else begin
                r_j <= r_j + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drain <= '0;
        end else if (r_state != S_DRAIN) begin
            r_drain <= '0;
        end else begin
            r_drain <= r_drain + 1'b1;
        end
    end

    // Write delay line ignores stall so a pixel already finished still gets written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_pipe <= '0;
            for (int i = 0; i < MAC_LAT; i++) begin
                r_oaddr_pipe[i] <= '0;
            end
        end else begin
            r_wr_pipe[0] <= w_acc_last;
            if (w_issue) begin
                r_oaddr_pipe[0] <= w_out_addr;
            end
            for (int i = 1; i < MAC_LAT; i++) begin
                r_wr_pipe[i]    <= r_wr_pipe[i-1];
                r_oaddr_pipe[i] <= r_oaddr_pipe[i-1];
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign mac_valid = w_issue;
    assign acc_clr   = w_issue && (r_k == 2'd0) && (r_j == 2'd0);
    assign acc_last  = w_acc_last;
    assign x_idx     = r_x;
    assign y_idx     = r_y;
    assign k_idx     = r_k;
    assign j_idx     = r_j;
    assign in_addr   = w_in_addr;
    assign out_wr    = r_wr_pipe[MAC_LAT-1];
    assign out_addr  = r_oaddr_pipe[MAC_LAT-1];

endmodule

// File: tb/tb_conv_loop_seq_l1.sv
// Bench for conv_loop_seq_l1: default geometry plus two 2x2/2x2 instances (stride 1 and 2).
module tb_conv_loop_seq_l1;

    localparam int N       = 8100;
    localparam int MAC_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic stall = 1'b0;
    logic start_s = 1'b0;
    logic stall_s = 1'b0;

    logic        busy, done, mac_valid, acc_clr, acc_last, out_wr;
    logic [4:0]  x_idx, y_idx;
    logic [1:0]  k_idx, j_idx;
    logic [11:0] in_addr, out_addr;

    logic        s1_busy, s1_done, s1_mac_valid, s1_acc_clr, s1_acc_last, s1_out_wr;
    logic [4:0]  s1_x, s1_y;
    logic [1:0]  s1_k, s1_j;
    logic [11:0] s1_in_addr, s1_out_addr;

    logic        s2_busy, s2_done, s2_mac_valid, s2_acc_clr, s2_acc_last, s2_out_wr;
    logic [4:0]  s2_x, s2_y;
    logic [1:0]  s2_k, s2_j;
    logic [11:0] s2_in_addr, s2_out_addr;

    conv_loop_seq_l1 u_dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .busy(busy), .done(done), .mac_valid(mac_valid), .acc_clr(acc_clr), .acc_last(acc_last),
        .x_idx(x_idx), .y_idx(y_idx), .k_idx(k_idx), .j_idx(j_idx),
        .in_addr(in_addr), .out_wr(out_wr), .out_addr(out_addr)
    );

    conv_loop_seq_l1 #(.OUT_W(2), .OUT_H(2), .K_H(2), .K_W(2), .STRIDE(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start_s), .stall(stall_s),
        .busy(s1_busy), .done(s1_done), .mac_valid(s1_mac_valid), .acc_clr(s1_acc_clr), .acc_last(s1_acc_last),
        .x_idx(s1_x), .y_idx(s1_y), .k_idx(s1_k), .j_idx(s1_j),
        .in_addr(s1_in_addr), .out_wr(s1_out_wr), .out_addr(s1_out_addr)
    );

    conv_loop_seq_l1 #(.OUT_W(2), .OUT_H(2), .K_H(2), .K_W(2), .STRIDE(2)) u_s2 (
        .clk(clk), .rst(rst), .start(start_s), .stall(stall_s),
        .busy(s2_busy), .done(s2_done), .mac_valid(s2_mac_valid), .acc_clr(s2_acc_clr), .acc_last(s2_acc_last),
        .x_idx(s2_x), .y_idx(s2_y), .k_idx(s2_k), .j_idx(s2_j),
        .in_addr(s2_in_addr), .out_wr(s2_out_wr), .out_addr(s2_out_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc; int x; int y; int k; int j; int addr; bit clr; bit last;
    } tap_t;
    typedef struct {
        int cyc; int addr;
    } wr_t;

    tap_t exp_tap[$];
    wr_t  exp_wr[$];
    int   exp_done[$];

    int tbl1 [16] = '{0,1,3,4, 1,2,4,5, 3,4,6,7, 4,5,7,8};
    int tbl2 [16] = '{0,1,4,5, 2,3,6,7, 8,9,12,13, 10,11,14,15};

    int t0s = 0;
    bit end_req = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    tap_t e;
    wr_t  w;
    int   d;
    int   p_tap = 0, p_clr = 0, p_last = 0, p_wr = 0;
    bit   chk_idle = 1'b0;
    int   n1 = 0, w1 = 0, d1 = 0, n2 = 0, d2 = 0;

    // Monitor: pops the scoreboard whenever the DUTs present something.
    always @(negedge clk) begin
        if (!rst) begin
            n_chk++;
            if ({busy, done, mac_valid, acc_clr, acc_last, out_wr} !== 6'b0 || x_idx !== 5'd0 || y_idx !== 5'd0 ||
                k_idx !== 2'd0 || j_idx !== 2'd0 || in_addr !== 12'd0 || out_addr !== 12'd0) begin
                n_fail++;
                $display("FAIL reset_state: ctl=%b x=%0d y=%0d k=%0d j=%0d in_addr=%0d out_addr=%0d, required all zero",
                         {busy, done, mac_valid, acc_clr, acc_last, out_wr}, x_idx, y_idx, k_idx, j_idx, in_addr, out_addr);
            end
            p_tap = 0; p_clr = 0; p_last = 0; p_wr = 0; chk_idle = 1'b0;
        end else begin
            if (chk_idle) begin
                chk_idle = 1'b0;
                n_chk++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_after_done: busy=%b done=%b, required 0 0", busy, done);
                end
            end
            if (stall) begin
                n_chk++;
                if (mac_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL valid_under_stall at cyc %0d: mac_valid=%b, required 0", cyc, mac_valid);
                end
            end
            if (mac_valid) begin
                p_tap++;
                if (acc_clr) p_clr++;
                if (acc_last) p_last++;
                n_chk++;
                if (exp_tap.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_tap at cyc %0d addr=%0d, required no tap", cyc, in_addr);
                end else begin
                    e = exp_tap.pop_front();
                    if (cyc != e.cyc || x_idx !== 5'(e.x) || y_idx !== 5'(e.y) || k_idx !== 2'(e.k) ||
                        j_idx !== 2'(e.j) || in_addr !== 12'(e.addr) || acc_clr !== e.clr || acc_last !== e.last) begin
                        n_fail++;
                        $display("FAIL tap: got cyc=%0d x=%0d y=%0d k=%0d j=%0d addr=%0d clr=%b last=%b, required cyc=%0d x=%0d y=%0d k=%0d j=%0d addr=%0d clr=%b last=%b",
                                 cyc, x_idx, y_idx, k_idx, j_idx, in_addr, acc_clr, acc_last,
                                 e.cyc, e.x, e.y, e.k, e.j, e.addr, e.clr, e.last);
                    end
                end
            end
            if (out_wr) begin
                p_wr++;
                n_chk++;
                if (exp_wr.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out_wr at cyc %0d addr=%0d, required none", cyc, out_addr);
                end else begin
                    w = exp_wr.pop_front();
                    if (cyc != w.cyc || out_addr !== 12'(w.addr)) begin
                        n_fail++;
                        $display("FAIL out_wr: got cyc=%0d addr=%0d, required cyc=%0d addr=%0d", cyc, out_addr, w.cyc, w.addr);
                    end
                end
            end
            if (done) begin
                n_chk++;
                if (exp_done.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done at cyc %0d, required none", cyc);
                end else begin
                    d = exp_done.pop_front();
                    if (cyc != d) begin
                        n_fail++;
                        $display("FAIL done_cycle: got %0d, required %0d", cyc, d);
                    end
                end
                n_chk++;
                if (p_tap != N || p_clr != 900 || p_last != 900 || p_wr != 900) begin
                    n_fail++;
                    $display("FAIL pass_counts: taps=%0d clr=%0d last=%0d wr=%0d, required 8100 900 900 900",
                             p_tap, p_clr, p_last, p_wr);
                end
                p_tap = 0; p_clr = 0; p_last = 0; p_wr = 0;
                chk_idle = 1'b1;
            end
            if (s1_mac_valid) begin
                n_chk++;
                if (n1 >= 16 || s1_in_addr !== 12'(tbl1[n1]) || cyc - t0s != n1 + 1 ||
                    s1_acc_clr !== (n1 % 4 == 0) || s1_acc_last !== (n1 % 4 == 3)) begin
                    n_fail++;
                    $display("FAIL s1_tap %0d: got cyc=%0d addr=%0d clr=%b last=%b, required cyc=%0d addr=%0d",
                             n1, cyc - t0s, s1_in_addr, s1_acc_clr, s1_acc_last, n1 + 1, (n1 < 16) ? tbl1[n1] : -1);
                end
                n1++;
            end
            if (s1_out_wr) begin
                n_chk++;
                if (cyc - t0s != 5 + 4 * w1 || s1_out_addr !== 12'(w1)) begin
                    n_fail++;
                    $display("FAIL s1_out_wr: got cyc=%0d addr=%0d, required cyc=%0d addr=%0d",
                             cyc - t0s, s1_out_addr, 5 + 4 * w1, w1);
                end
                w1++;
            end
            if (s1_done) begin
                n_chk++;
                if (cyc - t0s != 18) begin
                    n_fail++;
                    $display("FAIL s1_done: got cyc=%0d, required 18", cyc - t0s);
                end
                d1++;
            end
            if (s2_mac_valid) begin
                n_chk++;
                if (n2 >= 16 || s2_in_addr !== 12'(tbl2[n2])) begin
                    n_fail++;
                    $display("FAIL s2_tap %0d: got addr=%0d, required %0d", n2, s2_in_addr, (n2 < 16) ? tbl2[n2] : -1);
                end
                n2++;
            end
            if (s2_done) begin
                n_chk++;
                if (cyc - t0s != 18) begin
                    n_fail++;
                    $display("FAIL s2_done: got cyc=%0d, required 18", cyc - t0s);
                end
                d2++;
            end
        end
        if (end_req) begin
            n_chk++;
            if (exp_tap.size() != 0 || exp_wr.size() != 0 || exp_done.size() != 0) begin
                n_fail++;
                $display("FAIL leftover_expectations: taps=%0d wr=%0d done=%0d, required 0 0 0",
                         exp_tap.size(), exp_wr.size(), exp_done.size());
            end
            n_chk++;
            if (n1 != 16 || w1 != 4 || d1 != 1 || n2 != 16 || d2 != 1) begin
                n_fail++;
                $display("FAIL small_counts: s1 taps=%0d wr=%0d done=%0d s2 taps=%0d done=%0d, required 16 4 1 16 1",
                         n1, w1, d1, n2, d2);
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

    task automatic push_tap(inout int x, inout int y, inout int k, inout int j);
        exp_tap.push_back('{cyc, x, y, k, j, (y + k) * 32 + x + j, (k == 0 && j == 0), (k == 2 && j == 2)});
        if (k == 2 && j == 2) exp_wr.push_back('{cyc + MAC_LAT, y * 30 + x});
        j++;
        if (j == 3) begin
            j = 0; k++;
            if (k == 3) begin
                k = 0; x++;
                if (x == 30) begin
                    x = 0; y++;
                end
            end
        end
    endtask

    task automatic run_pass(input int stall_pct, input bit repulse);
        int x = 0, y = 0, k = 0, j = 0, issued = 0, stalls = 0, t0, dcyc;
        @(posedge clk); #1;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (issued < N) begin
            start = repulse && (cyc - t0 == 100);
            stall = ($urandom_range(0, 99) < stall_pct);
            if (stall) stalls++;
            else begin
                push_tap(x, y, k, j);
                issued++;
            end
            @(posedge clk); #1;
        end
        stall = 1'b0;
        start = 1'b0;
        dcyc = t0 + N + stalls + MAC_LAT + 1;
        exp_done.push_back(dcyc);
        while (cyc < dcyc) begin
            @(posedge clk); #1;
        end
        start = repulse;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_abort();
        int x = 0, y = 0, k = 0, j = 0, t0;
        @(posedge clk); #1;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc - t0 < 500) begin
            push_tap(x, y, k, j);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        exp_tap.delete();
        exp_wr.delete();
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b1;
        t0s = cyc;
        @(posedge clk); #1;
        start_s = 1'b0;
        repeat (22) begin @(posedge clk); #1; end
        run_pass(0, 1'b1);
        run_pass(30, 1'b0);
        run_abort();
        run_pass(0, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        end_req = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1, "time limit");
    end

endmodule
